// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
//  lift_pkg : shared types and bench-default timing for the lift car controller
//  Revision : 1.0
// ============================================================================
package lift_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } lift_state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } lift_dir_t;

   localparam int TB_TRAVEL_CYCLES = 4;
   localparam int TB_DOOR_CYCLES   = 6;

endpackage : lift_pkg
`default_nettype wire

// File: rtl/lift_timer.sv
`default_nettype none
// ============================================================================
//  lift_timer : terminal-count counter, done pulses on the last enabled cycle
//  Revision   : 1.0
// ============================================================================
module lift_timer #(
   parameter int CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CNT_W = $clog2(CYCLES);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             at_term;

   assign at_term = (count_q == CNT_W'(CYCLES - 1));
   // A clear in the terminal cycle suppresses done so a restart always wins.
   assign done    = en && !clr && at_term;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = at_term ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : lift_timer
`default_nettype wire

// File: rtl/lift_car_ctrl.sv
`default_nettype none
// ============================================================================
//  lift_car_ctrl : SCAN-ordered lift car controller behind a valid/ready port.
//  Option LIFT_DOOR_REOPEN_EN : a same-floor request holds the open door.
//  Revision      : 1.0
// ============================================================================
module lift_car_ctrl
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   output logic                  req_ready,
   output logic                  req_err,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic                  arrived,
   output logic [NUM_FLOORS-1:0] pending
);

   lift_state_t           state_q, state_d;
   lift_dir_t             last_dir_q, last_dir_d;
   logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d, step_floor;
   logic [NUM_FLOORS-1:0] pending_q, pending_d, set_mask, clr_mask, pend_seen;
   logic                  arrived_q, arrived_d, req_err_q, req_err_d;
   logic                  req_bad, door_reopen, any_above, any_below;
   logic                  travel_en, travel_done, door_en, door_clr, door_done;

   if (NUM_FLOORS == (1 << FLOOR_W)) begin : g_full_range
      assign req_bad = 1'b0;
   end else begin : g_partial_range
      assign req_bad = (32'(req_floor) >= 32'(NUM_FLOORS));
   end

`ifdef LIFT_DOOR_REOPEN_EN
   assign door_reopen = req_valid && !req_bad && (state_q == DOOR_OPEN) &&
                        (req_floor == cur_floor_q);
`else
   assign door_reopen = 1'b0;
`endif

   assign set_mask   = (req_valid && !req_bad && !door_reopen) ?
                       (NUM_FLOORS'(1) << req_floor) : '0;
   // Arrival on a step edge must also see a request landing on that same edge.
   assign pend_seen  = pending_q | set_mask;
   assign step_floor = (state_q == MOVE_UP) ? cur_floor_q + 1'b1 : cur_floor_q - 1'b1;

   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_q[i] && (i > int'(cur_floor_q))) any_above = 1'b1;
         if (pending_q[i] && (i < int'(cur_floor_q))) any_below = 1'b1;
      end
   end

   assign travel_en = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
   assign door_en   = (state_q == DOOR_OPEN);
   assign door_clr  = !door_en || door_reopen;

   lift_timer #(.CYCLES(TRAVEL_CYCLES)) u_travel_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (!travel_en),
      .en    (travel_en),
      .done  (travel_done)
   );

   lift_timer #(.CYCLES(DOOR_CYCLES)) u_door_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (door_clr),
      .en    (door_en),
      .done  (door_done)
   );

   always_comb begin
      state_d     = state_q;
      last_dir_d  = last_dir_q;
      cur_floor_d = cur_floor_q;
      arrived_d   = 1'b0;
      req_err_d   = req_valid && req_bad;
      clr_mask    = '0;
      case (state_q)
         IDLE: begin
            if (pending_q[cur_floor_q]) begin
               state_d   = DOOR_OPEN;
               arrived_d = 1'b1;
               clr_mask  = NUM_FLOORS'(1) << cur_floor_q;
            end else if (any_above && ((last_dir_q == DIR_UP) || !any_below)) begin
               state_d = MOVE_UP;
            end else if (any_below) begin
               state_d = MOVE_DOWN;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (travel_done) begin
               cur_floor_d = step_floor;
               last_dir_d  = (state_q == MOVE_UP) ? DIR_UP : DIR_DOWN;
               if (pend_seen[step_floor]) begin
                  state_d   = DOOR_OPEN;
                  arrived_d = 1'b1;
                  clr_mask  = NUM_FLOORS'(1) << step_floor;
               end
            end
         end
         default: begin
            if (door_done) state_d = IDLE;
         end
      endcase
      // The clear wins over a same-cycle set: the car is serving that floor.
      pending_d = pend_seen & ~clr_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_dir_q  <= DIR_UP;
         cur_floor_q <= '0;
         pending_q   <= '0;
         arrived_q   <= 1'b0;
         req_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dir_q  <= last_dir_d;
         cur_floor_q <= cur_floor_d;
         pending_q   <= pending_d;
         arrived_q   <= arrived_d;
         req_err_q   <= req_err_d;
      end
   end

   assign req_ready   = 1'b1;
   assign req_err     = req_err_q;
   assign cur_floor   = cur_floor_q;
   assign moving_up   = (state_q == MOVE_UP);
   assign moving_down = (state_q == MOVE_DOWN);
   assign door_open   = (state_q == DOOR_OPEN);
   assign arrived     = arrived_q;
   assign pending     = pending_q;

endmodule : lift_car_ctrl
`default_nettype wire

// File: tb/tb_lift_car_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_lift_car_ctrl : scoreboard bench, directed scenarios plus random requests
//  Revision         : 1.0
// ============================================================================
module tb_lift_car_ctrl;
   import lift_pkg::*;

   localparam int N  = 8;
   localparam int FW = 3;
   localparam int T  = TB_TRAVEL_CYCLES;
   localparam int D  = TB_DOOR_CYCLES;
`ifdef LIFT_DOOR_REOPEN_EN
   localparam int C_DOOR = D + 1;
   localparam int C_ARR  = 1;
`else
   localparam int C_DOOR = 2 * D;
   localparam int C_ARR  = 2;
`endif
   localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

   logic          clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
   logic [FW-1:0] req_floor = '0;
   logic          req_ready, req_err, moving_up, moving_down, door_open, arrived;
   logic [FW-1:0] cur_floor;
   logic [N-1:0]  pending;
   // Six-floor instance so that out-of-range floor indices exist.
   logic          e_valid = 1'b0;
   logic [2:0]    e_floor = '0;
   logic          e_ready, e_err, e_up, e_dn, e_door, e_arr;
   logic [2:0]    e_cur;
   logic [5:0]    e_pend;

   always #5 clk = ~clk;

   lift_car_ctrl #(.NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
      .req_ready(req_ready), .req_err(req_err), .cur_floor(cur_floor),
      .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open),
      .arrived(arrived), .pending(pending)
   );

   lift_car_ctrl #(.NUM_FLOORS(6), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut_err (
      .clk(clk), .reset(reset), .req_valid(e_valid), .req_floor(e_floor),
      .req_ready(e_ready), .req_err(e_err), .cur_floor(e_cur),
      .moving_up(e_up), .moving_down(e_dn), .door_open(e_door),
      .arrived(e_arr), .pending(e_pend)
   );

   int n_pass = 0, n_total = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: the car as a floor number, a request set and a countdown.
   int       m_mode = M_IDLE, m_floor = 0, m_rem = 0, edge_cnt = 0;
   bit       m_last_up = 1'b1, m_arr = 1'b0;
   bit [N-1:0] m_pend = '0;
   typedef struct { int floor; int at; } arr_t;
   arr_t     expq[$];
   int       arr_log[$];
   int       cnt_up = 0, cnt_dn = 0, cnt_door = 0, cnt_arr = 0;

   function automatic bit m_any(int lo, int hi);
      for (int i = lo; i <= hi; i++) if (i >= 0 && i < N && m_pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_arrive();
      m_mode = M_DOOR;
      m_rem  = D;
      m_arr  = 1'b1;
      m_pend[m_floor] = 1'b0;
      expq.push_back('{m_floor, edge_cnt});
   endtask

   task automatic m_step(bit v, int f);
      int add = -1;
      int served = -1;
      bit restart = 1'b0;
      m_arr = 1'b0;
      if (v) begin
`ifdef LIFT_DOOR_REOPEN_EN
         if (m_mode == M_DOOR && f == m_floor) restart = 1'b1;
         else add = f;
`else
         add = f;
`endif
      end
      case (m_mode)
         M_IDLE: begin
            if (m_pend[m_floor]) begin
               served = m_floor;
               m_arrive();
            end else if (m_any(m_floor + 1, N - 1) && (m_last_up || !m_any(0, m_floor - 1))) begin
               m_mode = M_UP;
               m_rem  = T;
            end else if (m_any(0, m_floor - 1)) begin
               m_mode = M_DOWN;
               m_rem  = T;
            end
         end
         M_UP, M_DOWN: begin
            m_rem--;
            if (m_rem == 0) begin
               m_last_up = (m_mode == M_UP);
               m_floor   = m_floor + (m_last_up ? 1 : -1);
               if (m_pend[m_floor] || add == m_floor) begin
                  served = m_floor;
                  m_arrive();
               end else begin
                  m_rem = T;
               end
            end
         end
         default: begin
            if (restart) m_rem = D;
            else begin
               m_rem--;
               if (m_rem == 0) m_mode = M_IDLE;
            end
         end
      endcase
      if (add >= 0 && add != served) m_pend[add] = 1'b1;
   endtask

   always @(posedge clk) begin
      edge_cnt++;
      if (reset) begin
         m_mode = M_IDLE; m_floor = 0; m_rem = 0; m_last_up = 1'b1;
         m_arr = 1'b0; m_pend = '0;
         expq.delete();
      end else begin
         m_step(req_valid, int'(req_floor));
      end
   end

   // Monitor: per-cycle status against the model, arrival events against the queue.
   always @(negedge clk) begin
      check("cur_floor", 64'(cur_floor), 64'(m_floor));
      check("pending", 64'(pending), 64'(m_pend));
      check("status", {req_ready, req_err, moving_up, moving_down, door_open, arrived},
            {1'b1, 1'b0, m_mode == M_UP, m_mode == M_DOWN, m_mode == M_DOOR, m_arr});
      if (moving_up === 1'b1)   cnt_up++;
      if (moving_down === 1'b1) cnt_dn++;
      if (door_open === 1'b1)   cnt_door++;
      if (arrived === 1'b1) begin
         cnt_arr++;
         arr_log.push_back(int'(cur_floor));
         check("arrival_queued", 64'(expq.size() > 0), 64'd1);
         if (expq.size() > 0) begin
            check("arrival_floor", 64'(cur_floor), 64'(expq[0].floor));
            check("arrival_edge", 64'(edge_cnt), 64'(expq[0].at));
            void'(expq.pop_front());
         end
      end
      if (expq.size() > 0 && expq[0].at < edge_cnt) begin
         check("arrival_missed", 64'(edge_cnt), 64'(expq[0].at));
         void'(expq.pop_front());
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(int f);
      req_valid = 1'b1;
      req_floor = FW'(f);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(string name, int budget);
      int n = 0;
      while (!(m_mode == M_IDLE && m_pend == '0) && n < budget) begin
         tick();
         n++;
      end
      check({name, "_idle_timeout"}, 64'(n < budget), 64'd1);
   endtask

   task automatic wait_moving_up(string name, int budget);
      int n = 0;
      while (moving_up !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check({name, "_move_timeout"}, 64'(n < budget), 64'd1);
   endtask

   task automatic wait_arrived(string name, int budget);
      int n = 0;
      while (arrived !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check({name, "_arrive_timeout"}, 64'(n < budget), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_up, s_dn, s_door, s_arr, s_log;
      tick();
      tick();
      check("reset_outputs", {cur_floor, pending, moving_up, moving_down, door_open,
            arrived, req_err, req_ready}, {3'd0, 8'h00, 5'b0, 1'b1});
      reset = 1'b0;
      tick();

      // Ground floor to floor 3.
      s_up = cnt_up; s_door = cnt_door; s_arr = cnt_arr;
      send(3);
      wait_idle("to3", 200);
      check("to3_up_cycles", 64'(cnt_up - s_up), 64'(3 * T));
      check("to3_door_cycles", 64'(cnt_door - s_door), 64'(D));
      check("to3_arrivals", 64'(cnt_arr - s_arr), 64'd1);
      check("to3_floor", 64'(cur_floor), 64'd3);

      // Asynchronous reset while climbing from 3 towards 7.
      send(7);
      wait_moving_up("midmove", 20);
      tick();
      check("midmove_pre", {cur_floor, pending, moving_up}, {3'd3, 8'h80, 1'b1});
      reset = 1'b1;
      #1;
      check("midmove_reset", {cur_floor, pending, moving_up, moving_down, door_open,
            arrived, req_err, req_ready}, {3'd0, 8'h00, 5'b0, 1'b1});
      tick();
      reset = 1'b0;
      tick();

      // From 2 heading to 6, then 4 and 1 arrive: serve 4, 6, then reverse to 1.
      send(2);
      wait_idle("to2", 200);
      s_log = arr_log.size();
      send(6);
      tick();
      send(4);
      send(1);
      wait_idle("scan", 400);
      check("scan_arrivals", 64'(arr_log.size() - s_log), 64'd3);
      if (arr_log.size() >= s_log + 3) begin
         check("scan_first", 64'(arr_log[s_log]), 64'd4);
         check("scan_second", 64'(arr_log[s_log + 1]), 64'd6);
         check("scan_third", 64'(arr_log[s_log + 2]), 64'd1);
      end

      // Idle at 5, request 5, then request 5 again while the door is open.
      send(5);
      wait_idle("to5", 300);
      s_up = cnt_up; s_dn = cnt_dn; s_door = cnt_door; s_arr = cnt_arr;
      send(5);
      wait_arrived("same", 10);
      send(5);
      wait_idle("reopen", 100);
      check("same_no_motion", 64'((cnt_up - s_up) + (cnt_dn - s_dn)), 64'd0);
      check("reopen_door_cycles", 64'(cnt_door - s_door), 64'(C_DOOR));
      check("reopen_arrivals", 64'(cnt_arr - s_arr), 64'(C_ARR));
      check("reopen_floor", 64'(cur_floor), 64'd5);

      // Out-of-range requests on the six-floor instance.
      e_valid = 1'b1; e_floor = 3'd7;
      tick();
      check("err7_pulse", {e_err, e_pend, e_ready}, {1'b1, 6'h00, 1'b1});
      e_floor = 3'd6;
      tick();
      check("err6_pulse", {e_err, e_pend}, {1'b1, 6'h00});
      e_valid = 1'b0;
      tick();
      check("err_after", {e_err, e_pend, e_up, e_dn, e_door, e_arr, e_cur},
            {1'b0, 6'h00, 4'b0, 3'd0});
      e_valid = 1'b1; e_floor = 3'd4;
      tick();
      check("err_valid_req", {e_err, e_pend}, {1'b0, 6'h10});
      e_valid = 1'b0;

      // Random request traffic with one reset mid-stream.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         req_valid = ($urandom_range(0, 4) == 0);
         req_floor = FW'($urandom_range(0, N - 1));
         tick();
      end
      req_valid = 1'b0;
      wait_idle("random", 3000);
      tick();
      check("queue_drained", 64'(expq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_lift_car_ctrl
`default_nettype wire
